// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter driving an 8-way load demux (sel/in) plus the matching
// one-hot grant, with lockable grants that are force-released after HOLD_MAX cycles.
module dmux8_rr_arbiter #(
   parameter int HOLD_MAX = 15,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic [7:0] lock,
   output logic [2:0] sel,
   output logic       in,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state_r, state_s;
   logic [2:0]    ptr_r, ptr_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [2:0]    sel_s;
   logic          in_s;
   logic [7:0]    gnt_s;
   logic          timeout_s;
   logic          held_s;
   logic          keep_s;
   logic [2:0]    start_s;
   logic          hit_s;
   logic [2:0]    win_s;

   // First requester at or after p (wrapping); result is {hit, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Next-state and next-output logic; a release re-searches from sel+1 in the same cycle.
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      cnt_s     = cnt_r;
      sel_s     = sel;
      in_s      = in;
      timeout_s = 1'b0;
      held_s    = req[sel] & lock[sel];
      keep_s    = (state_r == GRANT) && held_s && (cnt_r < CW'(HOLD_MAX));
      start_s   = (state_r == GRANT) ? (sel + 3'd1) : ptr_r;
      {hit_s, win_s} = rr_pick(req, start_s);
      case (state_r)
         IDLE: begin
            if (hit_s) begin
               state_s = GRANT;
               sel_s   = win_s;
               in_s    = 1'b1;
               cnt_s   = CW'(1);
            end else begin
               in_s    = 1'b0;
            end
         end
         GRANT: begin
            if (keep_s) begin
               cnt_s = cnt_r + CW'(1);
            end else begin
               ptr_s     = start_s;
               timeout_s = held_s;
               if (hit_s) begin
                  sel_s = win_s;
                  in_s  = 1'b1;
                  cnt_s = CW'(1);
               end else begin
                  state_s = IDLE;
                  in_s    = 1'b0;
                  cnt_s   = '0;
               end
            end
         end
         default: begin
            state_s = IDLE;
            in_s    = 1'b0;
            cnt_s   = '0;
         end
      endcase
      gnt_s = in_s ? (8'd1 << sel_s) : 8'd0;
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         ptr_r   <= 3'd0;
         cnt_r   <= '0;
         sel     <= 3'd0;
         in      <= 1'b0;
         gnt     <= 8'd0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         cnt_r   <= cnt_s;
         sel     <= sel_s;
         in      <= in_s;
         gnt     <= gnt_s;
         busy    <= in_s;
         timeout <= timeout_s;
      end
   end

endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Directed bench for dmux8_rr_arbiter: a cycle model of owner/hold/pointer is
// checked every cycle, and literal expectations pin the key scenarios.
module tb_dmux8_rr_arbiter;

   localparam int HOLD = 4;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic [7:0] lock;
   logic [2:0] sel;
   logic       in;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   dmux8_rr_arbiter #(.HOLD_MAX(HOLD), .CW(8)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock),
      .sel(sel), .in(in), .gnt(gnt), .busy(busy), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the resource, how long it has held it, where the next search starts.
   typedef struct packed {
      int   owner;
      int   held;
      int   ptr;
      int   sel;
      logic to;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t step(input mstate_t s, input logic [7:0] r, input logic [7:0] l);
      mstate_t n;
      int idx;
      n = s;
      n.to = 1'b0;
      if (s.owner >= 0 && r[s.owner] && l[s.owner] && s.held < HOLD) begin
         n.held = s.held + 1;
      end else begin
         if (s.owner >= 0) begin
            n.to  = r[s.owner] & l[s.owner];
            n.ptr = (s.owner + 1) % 8;
         end
         n.owner = -1;
         for (int i = 0; i < 8; i++) begin
            idx = (n.ptr + i) % 8;
            if (n.owner < 0 && r[idx]) n.owner = idx;
         end
         if (n.owner >= 0) begin
            n.sel  = n.owner;
            n.held = 1;
         end else begin
            n.held = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= '{owner: -1, held: 0, ptr: 0, sel: 0, to: 1'b0};
      else       m <= step(m, req, lock);
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] exp_g;
      logic       exp_in;
      exp_in = (m.owner >= 0);
      exp_g  = exp_in ? 8'(1 << m.sel) : 8'd0;
      chk("model_gnt", gnt, exp_g);
      chk("model_in", 8'(in), 8'(exp_in));
      chk("model_busy", 8'(busy), 8'(exp_in));
      chk("model_sel", 8'(sel), 8'(m.sel));
      chk("model_timeout", 8'(timeout), 8'(m.to));
   end

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] l;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl = '{'{8'h10, 8'h10}, '{8'h10, 8'h10}, '{8'h10, 8'h10}, '{8'h10, 8'h10},
              '{8'h10, 8'h10}, '{8'h10, 8'h10}, '{8'hA5, 8'hFF}, '{8'hA5, 8'h00},
              '{8'h81, 8'h80}, '{8'h00, 8'h00}};
      reset = 1'b1;
      req   = 8'h00;
      lock  = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_gnt", gnt, 8'h00);
      chk("reset_sel", 8'(sel), 8'h00);
      chk("reset_busy", 8'(busy), 8'h00);
      reset = 1'b0;

      // Reset in the middle of a locked grant to requester 3
      req  = 8'h08;
      lock = 8'h08;
      @(negedge clk);
      chk("grant3_gnt", gnt, 8'h08);
      chk("grant3_sel", 8'(sel), 8'h03);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_gnt", gnt, 8'h00);
      chk("async_rst_in", 8'(in), 8'h00);
      chk("async_rst_busy", 8'(busy), 8'h00);
      @(negedge clk);
      reset = 1'b0;
      req   = 8'h01;
      lock  = 8'h00;
      @(negedge clk);
      chk("post_rst_gnt", gnt, 8'h01);
      req = 8'h00;
      @(negedge clk);

      // Single one-cycle request from requester 5
      req = 8'h20;
      @(negedge clk);
      chk("single_gnt", gnt, 8'h20);
      chk("single_sel", 8'(sel), 8'h05);
      chk("single_in", 8'(in), 8'h01);
      req = 8'h00;
      @(negedge clk);
      chk("single_idle_gnt", gnt, 8'h00);
      chk("single_idle_busy", 8'(busy), 8'h00);
      chk("single_idle_sel", 8'(sel), 8'h05);

      // Fairness from ptr=0 with everyone requesting
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req   = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("fair_gnt", gnt, 8'(1 << (i % 8)));
         chk("fair_busy", 8'(busy), 8'h01);
      end
      req = 8'h00;
      @(negedge clk);

      // Forced release of a locked grant hands over to requester 6 with timeout
      req  = 8'h44;
      lock = 8'h04;
      for (int k = 0; k < HOLD; k++) begin
         @(negedge clk);
         chk("hold_gnt", gnt, 8'h04);
         chk("hold_timeout", 8'(timeout), 8'h00);
      end
      @(negedge clk);
      chk("to_gnt", gnt, 8'h40);
      chk("to_pulse", 8'(timeout), 8'h01);
      req  = 8'h00;
      lock = 8'h00;
      @(negedge clk);
      chk("to_end", 8'(timeout), 8'h00);
      chk("to_idle_gnt", gnt, 8'h00);

      // Pointer wrap after granting requester 3
      req = 8'h08;
      @(negedge clk);
      chk("wrap_g3", gnt, 8'h08);
      req = 8'h09;
      @(negedge clk);
      chk("wrap_g0", gnt, 8'h01);
      @(negedge clk);
      chk("wrap_g3b", gnt, 8'h08);
      req = 8'h00;
      @(negedge clk);

      // Lock dropped in the third granted cycle
      req  = 8'h02;
      lock = 8'h02;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("lockdrop_gnt", gnt, 8'h02);
         chk("lockdrop_to", 8'(timeout), 8'h00);
      end
      req  = 8'h00;
      lock = 8'h00;
      @(negedge clk);
      chk("lockdrop_idle", gnt, 8'h00);

      // Mixed vectors, including a lone requester regaining after a forced release
      for (int v = 0; v < 10; v++) begin
         req  = tbl[v].r;
         lock = tbl[v].l;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
